// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the multi-cycle processor core.
//   - opcode and ALU operation encodings
//   - special register indices (r30 status, r31 return address)
//   - overflow status codes written to r30
//   - FSM state enumeration
//   - read_regs(): decodes the regfile read addresses from an instruction word
// No ports (package).
// ---------------------------------------------------------------------------
package proc_pkg;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLL = 5'd4;
    localparam logic [4:0] ALU_SRA = 5'd5;

    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_RA     = 5'd31;

    localparam logic [31:0] OVF_ADD  = 32'd1;
    localparam logic [31:0] OVF_ADDI = 32'd2;
    localparam logic [31:0] OVF_SUB  = 32'd3;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    // Returns {read_a, read_b}. Unused ports read r0.
    function automatic logic [9:0] read_regs(input logic [31:0] instr);
        logic [4:0] ra;
        logic [4:0] rb;
        ra = 5'd0;
        rb = 5'd0;
        case (instr[31:27])
            OP_R: begin
                ra = instr[21:17];
                rb = instr[16:12];
            end
            OP_ADDI, OP_LW: begin
                ra = instr[21:17];
            end
            OP_SW: begin
                ra = instr[21:17];
                rb = instr[26:22];
            end
            OP_BNE, OP_BLT: begin
                ra = instr[26:22];
                rb = instr[21:17];
            end
            OP_JR: begin
                ra = instr[26:22];
            end
            OP_BEX: begin
                ra = REG_STATUS;
            end
            default: begin
            end
        endcase
        return {ra, rb};
    endfunction

endpackage

// File: rtl/proc_alu.sv
// ---------------------------------------------------------------------------
// proc_alu
// Combinational 32-bit ALU.
// Ports:
//   a, b    in  32  operands
//   op      in  5   operation (add/sub/and/or/sll/sra)
//   shamt   in  5   shift amount for sll/sra
//   result  out 32  operation result (0 for unknown ops)
//   ne      out 1   a != b
//   lt      out 1   a < b, signed
//   ovf     out 1   signed overflow, only for add/sub
// ---------------------------------------------------------------------------
module proc_alu
    import proc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  op,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        ne,
    output logic        lt,
    output logic        ovf
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Overflow: operands of equal sign (add) or opposite sign (sub) whose
    // result sign differs from a.
    always_comb begin
        result = 32'd0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum;
                ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLL: result = a << shamt;
            ALU_SRA: result = $signed(a) >>> shamt;
            default: result = 32'd0;
        endcase
    end

    assign ne = (a != b);
    assign lt = ($signed(a) < $signed(b));

endmodule

// File: rtl/processor_mc.sv
// ---------------------------------------------------------------------------
// processor_mc
// Multi-cycle 32-bit core: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Optional build macro: PERF_CNT_EN adds cycle_cnt / instr_cnt outputs.
// Parameters:
//   ADDR_W    width of PC and memory addresses (PC wraps modulo 2^ADDR_W)
//   RESET_PC  PC value after reset
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   address_imem / q_imem        instruction fetch (one-cycle read latency)
//   address_dmem, data, wren     data memory address, store data, store enable
//   dmem_req / dmem_ready        variable-latency data memory handshake
//   q_dmem                       load data, valid when dmem_ready is high
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg   regfile write port
//   ctrl_readRegA/B, data_readRegA/B                 regfile read ports
//   retire                       one-cycle pulse per completed instruction
//   cycle_cnt, instr_cnt         (PERF_CNT_EN only) performance counters
// ---------------------------------------------------------------------------
module processor_mc
    import proc_pkg::*;
#(
    parameter int              ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [31:0]       q_imem,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [31:0]       data,
    output logic              wren,
    output logic              dmem_req,
    input  logic              dmem_ready,
    input  logic [31:0]       q_dmem,
    output logic              ctrl_writeEnable,
    output logic [4:0]        ctrl_writeReg,
    output logic [4:0]        ctrl_readRegA,
    output logic [4:0]        ctrl_readRegB,
    output logic [31:0]       data_writeReg,
    input  logic [31:0]       data_readRegA,
    input  logic [31:0]       data_readRegB,
    output logic              retire
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
`endif
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [31:0]       opa_q;
    logic              ne_q;
    logic              lt_q;

    logic [4:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [4:0]        aluop;
    logic [31:0]       imm_ext;
    logic [31:0]       target_ext;

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] target_pc;
    logic [ADDR_W-1:0] next_pc;

    logic [31:0]       alu_b;
    logic [4:0]        alu_op;
    logic [31:0]       alu_result;
    logic              alu_ne;
    logic              alu_lt;
    logic              alu_ovf;

    logic              is_mem;
    logic              is_sw;
    logic              wb_we;
    logic [4:0]        wb_reg;
    logic [31:0]       wb_data;

    assign opcode     = ir[31:27];
    assign rd         = ir[26:22];
    assign shamt      = ir[11:7];
    assign aluop      = ir[6:2];
    assign imm_ext    = {{15{ir[16]}}, ir[16:0]};
    assign target_ext = {5'd0, ir[26:0]};

    assign pc_plus1   = pc + ADDR_W'(1);
    assign branch_pc  = pc_plus1 + imm_ext[ADDR_W-1:0];
    assign target_pc  = ir[ADDR_W-1:0];

    assign address_imem = pc;
    assign is_sw        = (opcode == OP_SW);
    assign is_mem       = (opcode == OP_LW) || is_sw;

    // ALU operand/operation select. Branches subtract so the flags come from
    // a clean compare; memory ops and addi add the sign-extended immediate.
    always_comb begin
        alu_b  = data_readRegB;
        alu_op = ALU_ADD;
        case (opcode)
            OP_R:                 alu_op = aluop;
            OP_ADDI, OP_LW, OP_SW: alu_b = imm_ext;
            OP_BNE, OP_BLT:       alu_op = ALU_SUB;
            default:              alu_op = ALU_ADD;
        endcase
    end

    proc_alu u_alu (
        .a      (data_readRegA),
        .b      (alu_b),
        .op     (alu_op),
        .shamt  (shamt),
        .result (alu_result),
        .ne     (alu_ne),
        .lt     (alu_lt),
        .ovf    (alu_ovf)
    );

    // Writeback values, computed in the cycle that leaves EXEC (live ALU
    // result) or MEM (live q_dmem) so the WB outputs can be registered.
    // Overflow redirects the write to r30 with a status code; a resolved
    // destination of r0 never writes.
    always_comb begin
        wb_we   = 1'b0;
        wb_reg  = rd;
        wb_data = alu_result;
        case (opcode)
            OP_R: begin
                wb_we = 1'b1;
                if (alu_ovf) begin
                    wb_reg  = REG_STATUS;
                    wb_data = (aluop == ALU_SUB) ? OVF_SUB : OVF_ADD;
                end
            end
            OP_ADDI: begin
                wb_we = 1'b1;
                if (alu_ovf) begin
                    wb_reg  = REG_STATUS;
                    wb_data = OVF_ADDI;
                end
            end
            OP_LW: begin
                wb_we   = 1'b1;
                wb_data = q_dmem;
            end
            OP_JAL: begin
                wb_we   = 1'b1;
                wb_reg  = REG_RA;
                wb_data = 32'(pc_plus1);
            end
            OP_SETX: begin
                wb_we   = 1'b1;
                wb_reg  = REG_STATUS;
                wb_data = target_ext;
            end
            default: begin
                wb_we = 1'b0;
            end
        endcase
        if (wb_reg == 5'd0) begin
            wb_we = 1'b0;
        end
    end

    // PC selected at the end of WB from the flags and operand latched in EXEC.
    always_comb begin
        next_pc = pc_plus1;
        case (opcode)
            OP_J, OP_JAL: next_pc = target_pc;
            OP_BEX:       next_pc = (opa_q != 32'd0) ? target_pc : pc_plus1;
            OP_BNE:       next_pc = ne_q ? branch_pc : pc_plus1;
            OP_BLT:       next_pc = lt_q ? branch_pc : pc_plus1;
            OP_JR:        next_pc = opa_q[ADDR_W-1:0];
            default:      next_pc = pc_plus1;
        endcase
    end

    // Main FSM. Read addresses are registered at the end of DECODE and held
    // until the next DECODE so regfile data stays stable through MEM and WB.
    // data_writeReg doubles as the MDR for loads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= FETCH;
            pc               <= RESET_PC;
            ir               <= 32'd0;
            opa_q            <= 32'd0;
            ne_q             <= 1'b0;
            lt_q             <= 1'b0;
            address_dmem     <= '0;
            data             <= 32'd0;
            wren             <= 1'b0;
            dmem_req         <= 1'b0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= 5'd0;
            ctrl_readRegA    <= 5'd0;
            ctrl_readRegB    <= 5'd0;
            data_writeReg    <= 32'd0;
            retire           <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    ir                             <= q_imem;
                    {ctrl_readRegA, ctrl_readRegB} <= read_regs(q_imem);
                    state                          <= EXEC;
                end
                EXEC: begin
                    opa_q        <= data_readRegA;
                    data         <= data_readRegB;
                    ne_q         <= alu_ne;
                    lt_q         <= alu_lt;
                    address_dmem <= alu_result[ADDR_W-1:0];
                    if (is_mem) begin
                        dmem_req <= 1'b1;
                        wren     <= is_sw;
                        state    <= MEM;
                    end else begin
                        ctrl_writeEnable <= wb_we;
                        ctrl_writeReg    <= wb_reg;
                        data_writeReg    <= wb_data;
                        retire           <= 1'b1;
                        state            <= WB;
                    end
                end
                MEM: begin
                    if (dmem_ready) begin
                        dmem_req         <= 1'b0;
                        wren             <= 1'b0;
                        ctrl_writeEnable <= wb_we;
                        ctrl_writeReg    <= wb_reg;
                        data_writeReg    <= wb_data;
                        retire           <= 1'b1;
                        state            <= WB;
                    end
                end
                WB: begin
                    ctrl_writeEnable <= 1'b0;
                    retire           <= 1'b0;
                    pc               <= next_pc;
                    state            <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_processor_mc.sv
// ---------------------------------------------------------------------------
// tb_processor_mc
// Bench for processor_mc (ADDR_W=6, RESET_PC=5). Models imem, dmem with
// random latency and a regfile around the core. An instruction-level model
// predicts each retired instruction; a monitor compares at every retire and
// every MEM cycle.
// ---------------------------------------------------------------------------
module tb_processor_mc;

    localparam int AW     = 6;
    localparam int DEPTH  = 64;
    localparam int NINSTR = 300;

    localparam logic [4:0] T_R = 5'b00000, T_J = 5'b00001, T_BNE = 5'b00010;
    localparam logic [4:0] T_JAL = 5'b00011, T_JR = 5'b00100, T_ADDI = 5'b00101;
    localparam logic [4:0] T_BLT = 5'b00110, T_SW = 5'b00111, T_LW = 5'b01000;
    localparam logic [4:0] T_SETX = 5'b10101, T_BEX = 5'b10110;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] address_imem;
    logic [31:0]   q_imem = 32'd0;
    logic [AW-1:0] address_dmem;
    logic [31:0]   data;
    logic          wren;
    logic          dmem_req;
    logic          dmem_ready = 1'b0;
    logic [31:0]   q_dmem;
    logic          ctrl_writeEnable;
    logic [4:0]    ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0]   data_writeReg, data_readRegA, data_readRegB;
    logic          retire;

    always #5 clock = ~clock;

    processor_mc #(.ADDR_W(AW), .RESET_PC(6'd5)) dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .q_imem           (q_imem),
        .address_dmem     (address_dmem),
        .data             (data),
        .wren             (wren),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .q_dmem           (q_dmem),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .retire           (retire)
    );

    logic [31:0] imem [DEPTH];
    logic [31:0] dmem_hw [DEPTH];
    logic [31:0] regs_hw [32];
    logic [31:0] regs_init [32];
    logic [31:0] regs_m [32];
    logic [31:0] dmem_m [DEPTH];
    int          pc_m;
    bit          load_regs = 1'b1;

    typedef struct {
        bit          we;
        int          wreg;
        logic [31:0] wdata;
        int          npc;
        bit          is_mem;
    } exp_t;
    typedef struct {
        bit          st;
        int          addr;
        logic [31:0] sdata;
    } mem_t;
    exp_t exp_q[$];
    mem_t mem_q[$];

    int checks = 0;
    int errors = 0;
    bit run_active = 1'b0;
    int cyc_since = 0;
    int retired = 0;
    int lat = 1;
    int last_lat = 0;
    int memcnt = 0;
    bit pc_pending = 1'b0;
    int pend_pc = 0;
    bit first_retire = 1'b1;

    // Instruction memory with one-cycle read latency.
    always @(posedge clock) q_imem <= imem[address_imem];

    // Regfile: bulk load while held in reset, otherwise take DUT writes.
    always @(posedge clock) begin
        if (load_regs) begin
            for (int i = 0; i < 32; i++) regs_hw[i] <= regs_init[i];
        end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
            regs_hw[ctrl_writeReg] <= data_writeReg;
        end
    end

    assign data_readRegA = regs_hw[ctrl_readRegA];
    assign data_readRegB = regs_hw[ctrl_readRegB];
    assign q_dmem        = dmem_hw[address_dmem];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(int rd, int rs, int rt, int sh, int aop);
        return {T_R, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(aop), 2'b00};
    endfunction
    function automatic logic [31:0] enc_i(logic [4:0] op, int rd, int rs, int imm);
        return {op, 5'(rd), 5'(rs), 17'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(logic [4:0] op, int tgt);
        return {op, 27'(tgt)};
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        int rd, rs, rt;
        rd = $urandom_range(0, 31);
        rs = $urandom_range(0, 31);
        rt = $urandom_range(0, 31);
        k  = $urandom_range(0, 14);
        case (k)
            0, 1, 2: return enc_r(rd, rs, rt, $urandom_range(0, 31), $urandom_range(0, 5));
            3:  return enc_i(T_ADDI, rd, rs, $urandom_range(0, 131071));
            4:  return enc_i(T_LW, rd, rs, $urandom_range(0, 131071));
            5:  return enc_i(T_SW, rd, rs, $urandom_range(0, 131071));
            6:  return enc_i(T_BNE, rd, rs, $urandom_range(0, 131071));
            7:  return enc_i(T_BLT, rd, rs, $urandom_range(0, 131071));
            8:  return enc_j(T_J, $urandom);
            9:  return enc_j(T_JAL, $urandom);
            10: return enc_i(T_JR, rd, 0, 0);
            11: return enc_j(T_SETX, $urandom);
            12: return enc_j(T_BEX, $urandom);
            13: return enc_j(5'b01001, $urandom);
            default: return enc_j(5'b11000, $urandom);
        endcase
    endfunction

    // Architectural model: executes one instruction and records what the
    // core must show when it retires it.
    task automatic iss_step();
        logic [31:0] ins, a, b, res;
        logic [4:0]  op, rd, rs, rt, sh, aop;
        int          imm, addr;
        longint      s;
        bit          wr, ovf;
        exp_t        e;
        mem_t        m;
        ins = imem[pc_m];
        op  = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
        sh  = ins[11:7];  aop = ins[6:2];
        imm = ins[16] ? int'(ins[16:0]) - 131072 : int'(ins[16:0]);
        wr = 1'b0; ovf = 1'b0; res = 32'd0;
        e.we = 1'b0; e.wreg = 0; e.wdata = 32'd0; e.is_mem = 1'b0;
        e.npc = (pc_m + 1) % DEPTH;
        case (op)
            T_R, T_ADDI: begin
                a = regs_m[rs];
                b = (op == T_ADDI) ? 32'(imm) : regs_m[rt];
                if (op == T_ADDI) aop = 5'd0;
                case (aop)
                    5'd0: begin
                        s = longint'($signed(a)) + longint'($signed(b));
                        res = a + b;
                        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                    end
                    5'd1: begin
                        s = longint'($signed(a)) - longint'($signed(b));
                        res = a - b;
                        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                    end
                    5'd2: res = a & b;
                    5'd3: res = a | b;
                    5'd4: res = a << sh;
                    5'd5: res = 32'($signed(a) >>> sh);
                    default: res = 32'd0;
                endcase
                wr = 1'b1;
                if (ovf) begin
                    e.wreg  = 30;
                    e.wdata = (op == T_ADDI) ? 32'd2 : ((aop == 5'd1) ? 32'd3 : 32'd1);
                end else begin
                    e.wreg  = rd;
                    e.wdata = res;
                end
            end
            T_LW, T_SW: begin
                addr = int'(regs_m[rs] + 32'(imm)) & (DEPTH - 1);
                e.is_mem = 1'b1;
                m.st = (op == T_SW); m.addr = addr; m.sdata = regs_m[rd];
                mem_q.push_back(m);
                if (op == T_SW) begin
                    dmem_m[addr] = regs_m[rd];
                end else begin
                    wr = 1'b1; e.wreg = rd; e.wdata = dmem_m[addr];
                end
            end
            T_J:    e.npc = int'(ins[26:0]) % DEPTH;
            T_JAL: begin
                wr = 1'b1; e.wreg = 31; e.wdata = 32'((pc_m + 1) % DEPTH);
                e.npc = int'(ins[26:0]) % DEPTH;
            end
            T_JR:   e.npc = int'(regs_m[rd] % DEPTH);
            T_BNE:  if (regs_m[rd] != regs_m[rs]) e.npc = (pc_m + 1 + imm) & (DEPTH - 1);
            T_BLT:  if ($signed(regs_m[rd]) < $signed(regs_m[rs])) e.npc = (pc_m + 1 + imm) & (DEPTH - 1);
            T_SETX: begin
                wr = 1'b1; e.wreg = 30; e.wdata = {5'd0, ins[26:0]};
            end
            T_BEX:  if (regs_m[30] != 32'd0) e.npc = int'(ins[26:0]) % DEPTH;
            default: begin
            end
        endcase
        e.we = wr && (e.wreg != 0);
        if (e.we) regs_m[e.wreg] = e.wdata;
        exp_q.push_back(e);
        pc_m = e.npc;
    endtask

    // Memory responder plus scoreboard monitor, all sampled mid-cycle.
    always @(negedge clock) begin
        if (!run_active) begin
            dmem_ready = 1'b0;
            memcnt = 0;
            for (int i = 0; i < DEPTH; i++) dmem_hw[i] = 32'd0;
        end else begin
            exp_t e;
            int   gap;
            cyc_since++;
            if (dmem_req) begin
                if (memcnt == 0) lat = $urandom_range(1, 4);
                memcnt++;
                dmem_ready = (memcnt == lat);
            end else begin
                memcnt = 0;
                dmem_ready = 1'($urandom_range(0, 1));
            end
            if (pc_pending) begin
                checkOutput("next_pc", 32'(address_imem), 32'(pend_pc));
                pc_pending = 1'b0;
            end
            if (dmem_req) begin
                if (mem_q.size() == 0) begin
                    checkOutput("mem_unexpected", 32'(dmem_req), 32'd0);
                end else begin
                    checkOutput("mem_addr", 32'(address_dmem), 32'(mem_q[0].addr));
                    checkOutput("mem_wren", 32'(wren), 32'(mem_q[0].st));
                    if (mem_q[0].st) checkOutput("mem_data", data, mem_q[0].sdata);
                    if (dmem_ready) begin
                        if (wren) dmem_hw[address_dmem] = data;
                        last_lat = lat;
                        void'(mem_q.pop_front());
                    end
                end
            end else begin
                checkOutput("wren_idle", 32'(wren), 32'd0);
            end
            if (retire) begin
                if (exp_q.size() == 0) begin
                    checkOutput("retire_unexpected", 32'(retire), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wb_enable", 32'(ctrl_writeEnable), 32'(e.we));
                    if (e.we) begin
                        checkOutput("wb_reg", 32'(ctrl_writeReg), 32'(e.wreg));
                        checkOutput("wb_data", data_writeReg, e.wdata);
                    end
                    gap = first_retire ? 3 : (4 + (e.is_mem ? last_lat : 0));
                    checkOutput("latency", 32'(cyc_since), 32'(gap));
                    pend_pc = e.npc;
                    pc_pending = 1'b1;
                end
                cyc_since = 0;
                first_retire = 1'b0;
                retired++;
            end
        end
    end

    task automatic applyStimulus();
        for (int i = 0; i < DEPTH; i++) imem[i] = rand_instr();
        imem[5]  = enc_i(T_ADDI, 1, 0, 7);
        imem[6]  = enc_r(2, 1, 1, 0, 0);
        imem[7]  = enc_i(T_SW, 2, 0, 3);
        imem[8]  = enc_r(7, 5, 6, 0, 0);
        imem[9]  = enc_i(T_LW, 8, 0, 3);
        imem[10] = enc_i(T_BNE, 1, 2, 4);
        imem[15] = enc_i(T_BLT, 2, 1, 2);
        imem[16] = enc_j(T_J, 20);
        imem[20] = enc_j(T_JAL, 63);
        imem[63] = enc_j(5'b11111, 0);
        for (int i = 0; i < 32; i++) regs_init[i] = (i == 0) ? 32'd0 : $urandom;
        regs_init[5] = 32'h7FFF_FFFF;
        regs_init[6] = 32'd1;
    endtask

    initial begin
        applyStimulus();
        // Reset state and the directed store interrupted by reset.
        repeat (3) @(negedge clock);
        checkOutput("rst_address_imem", 32'(address_imem), 32'd5);
        checkOutput("rst_retire", 32'(retire), 32'd0);
        checkOutput("rst_wren", 32'(wren), 32'd0);
        checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_we", 32'(ctrl_writeEnable), 32'd0);
        checkOutput("rst_address_dmem", 32'(address_dmem), 32'd0);
        checkOutput("rst_data_writeReg", data_writeReg, 32'd0);
        checkOutput("rst_regs", {17'd0, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB}, 32'd0);
        load_regs = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("decode_retire", 32'(retire), 32'd0);
        for (int i = 0; i < 50 && !dmem_req; i++) @(negedge clock);
        checkOutput("sw_req", 32'(dmem_req), 32'd1);
        checkOutput("sw_wren", 32'(wren), 32'd1);
        checkOutput("sw_addr", 32'(address_dmem), 32'd3);
        checkOutput("sw_data", data, 32'd14);
        repeat (2) @(negedge clock);
        checkOutput("sw_req_held", 32'(dmem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_req_drop", 32'(dmem_req), 32'd0);
        checkOutput("async_wren_drop", 32'(wren), 32'd0);
        checkOutput("async_no_retire", 32'(retire), 32'd0);
        checkOutput("async_no_write", 32'(ctrl_writeEnable), 32'd0);
        checkOutput("async_pc", 32'(address_imem), 32'd5);

        // Randomized run checked against the instruction-level model.
        for (int i = 0; i < 32; i++) regs_m[i] = regs_init[i];
        for (int i = 0; i < DEPTH; i++) dmem_m[i] = 32'd0;
        pc_m = 5;
        for (int i = 0; i < NINSTR; i++) iss_step();
        load_regs = 1'b1;
        repeat (2) @(negedge clock);
        load_regs = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1 run_active = 1'b1;
        for (int i = 0; i < 20000 && retired < NINSTR; i++) @(negedge clock);
        if (retired < NINSTR) checkOutput("retire_timeout", 32'(retired), 32'(NINSTR));
        @(negedge clock);
        run_active = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/processor_mc.md
Name: processor_mc

Overview:
- Multi-cycle successor to the single-cycle core; same 32-bit ISA, same regfile and imem/dmem port families.
- Each instruction runs through a FETCH/DECODE/EXEC/MEM/WB state machine with registered IR, operand and ALU-result latches.
- Address width and reset vector are parametrised.
- Adds a variable-latency dmem handshake (req/ready) and a one-cycle-per-instruction retire strobe.

Parameters:
- ADDR_W, 12, width of PC, imem and dmem addresses; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous, active-low reset
- address_imem  out  ADDR_W  registered PC; imem returns q_imem one cycle later
- q_imem  in  32  instruction word
- address_dmem  out  ADDR_W  ALU result low bits, held for the whole MEM state
- data  out  32  store data (data_readRegB)
- wren  out  1  store enable; high only while dmem_req is high for sw
- dmem_req  out  1  dmem access request, MEM state only
- dmem_ready  in  1  access complete; q_dmem is valid in the same cycle
- q_dmem  in  32  load data
- ctrl_writeEnable  out  1  regfile write, WB only
- ctrl_writeReg, ctrl_readRegA, ctrl_readRegB  out  5  regfile addresses
- data_writeReg  out  32  regfile write data
- data_readRegA, data_readRegB  in  32  combinational regfile read data
- retire  out  1  one-cycle pulse in WB

Behaviour:
- Reset state (asynchronous): state=FETCH, PC=RESET_PC, IR=0.
  - wren, dmem_req, ctrl_writeEnable and retire are all 0.
  - address_dmem, data_writeReg and all regfile addresses are 0.
- Opcodes: R=00000, j=00001, bne=00010, jal=00011, jr=00100, addi=00101, blt=00110, sw=00111, lw=01000, setx=10101, bex=10110.
  - Any other opcode executes as a nop: passes all states, no write, PC+1.
- ALU ops: add=0, sub=1, and=2, or=3, sll=4, sra=5. addi uses add.
- Fields:
  - rd=[26:22], rs=[21:17], rt=[16:12], shamt=[11:7], aluop=[6:2].
  - imm = sign-extended [16:0].
  - target = zero-extended [26:0], truncated to ADDR_W for the PC.
- FETCH (1 cycle): address_imem=PC. Next state DECODE.
- DECODE (1 cycle): IR<=q_imem. Next state EXEC.
- EXEC (1 cycle):
  - Regfile read addresses decoded from IR:
    - R: A=rs, B=rt.
    - addi/lw/sw: A=rs; sw also B=rd.
    - bne/blt: A=rd, B=rs.
    - jr: A=rd.
    - bex: A=30.
  - Latches at end of cycle: ALUOUT, the operands, and the flags ne, lt (A<B signed) and ovf.
  - Next state: MEM for lw/sw, else WB.
- MEM (≥1 cycle):
  - dmem_req=1; wren=1 for sw. Read addresses are held so data stays stable.
  - Stays in MEM until dmem_ready=1 is sampled. Load data is latched into MDR in that cycle.
  - dmem_ready seen in the first MEM cycle gives a 1-cycle MEM.
  - dmem_ready is ignored outside MEM.
- WB (1 cycle): retire=1.
  - ctrl_writeEnable=1 for R/addi/lw/jal/setx, and 0 whenever the resolved destination is r0.
  - Write data:
    - ALU result for R/addi.
    - MDR for lw.
    - PC+1 (zero-extended) for jal, written to r31.
    - target for setx, written to r30.
  - Overflow on add/addi/sub: destination becomes r30, data becomes 1/2/3 respectively, and rd is not written.
  - PC update:
    - target for j, jal, and bex when r30≠0.
    - PC+1+imm for bne-taken and blt-taken (rd<rs signed).
    - data_readRegA[ADDR_W-1:0] for jr.
    - Otherwise PC+1.
  - Next state FETCH.
- Latency: 4 cycles for non-memory instructions; 4+N for lw/sw, where N is the number of MEM cycles.
- All PC arithmetic is modulo 2^ADDR_W; PC=2^ADDR_W-1 followed by +1 gives 0.
- Reset asserted mid-MEM: dmem_req and wren drop asynchronously. No regfile write happens and retire is not pulsed.

Optional Feature:
- PERF_CNT_EN defined:
  - Adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle; instr_cnt increments on retire.
  - Both wrap at 2^32.
- Not defined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package proc_pkg holds:
  - opcode constants, ALU op constants, r30/r31 indices;
  - the state enum (FETCH, DECODE, EXEC, MEM, WB);
  - overflow status codes 1/2/3.
- One sub-module, proc_alu: combinational; inputs A, B, op, shamt; outputs result, ne, lt, ovf.

Test Plan:
- Reset release with RESET_PC=5 -> address_imem=5. First retire occurs 4 cycles after the first FETCH; outputs stay 0 until WB.
- addi r1,r0,7 then add r2,r1,r1 -> r1=7, then r2=14. retire pulses 4 cycles apart; no wren.
- sw r2,3(r0) with dmem_ready delayed 3 cycles -> dmem_req and wren held for 3 cycles, address_dmem=3, data=14. Retire 7 cycles after FETCH.
- add overflow on 0x7FFFFFFF+1 -> ctrl_writeReg=30 with data_writeReg=1; rd is not written.
- bne r1,r2,+4 at PC=10 (7≠14) -> next fetch at 15. blt not taken -> next fetch at PC+1.
- PC=2^ADDR_W-1 executing nop -> next address_imem=0. jal at PC=20 -> r31=21, PC=target.
